// File: rtl/ssg_dac_out.sv
// Stereo soft-mute gain ramp followed by first-order delta-sigma 1-bit DACs.
// Pipeline: capture on enable, scale one clk later, modulate every clk.
module ssg_dac_out #(
  parameter int DATA_W   = 12,
  parameter int GAIN_MAX = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [DATA_W-1:0] sound_in_l,
  input  logic [DATA_W-1:0] sound_in_r,
  input  logic              mute,
  output logic              dac_l,
  output logic              dac_r,
  output logic              muted
);

  localparam int SH = $clog2(GAIN_MAX);
  localparam int GW = SH + 1;
  localparam int PW = DATA_W + GW;
  localparam logic [GW-1:0] GAIN_FULL = GW'(GAIN_MAX);
  localparam logic [GW-1:0] GAIN_ZERO = {GW{1'b0}};
  localparam logic [GW-1:0] GAIN_ONE  = {{(GW-1){1'b0}}, 1'b1};

  logic [GW-1:0]     gain_q, gain_d;
  logic [GW-1:0]     gain_s_q, gain_s_d;
  logic [DATA_W-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic              cap_q, cap_d;
  logic [DATA_W-1:0] scaled_l_q, scaled_l_d, scaled_r_q, scaled_r_d;
  logic [DATA_W-1:0] acc_l_q, acc_l_d, acc_r_q, acc_r_d;
  logic              dac_l_q, dac_l_d, dac_r_q, dac_r_d;
  logic              muted_q, muted_d;
  logic [PW-1:0]     prod_l_s, prod_r_s;
  logic [DATA_W:0]   sum_l_s, sum_r_s;

  // Next-state: capture and gain step on strobes, scale one clk later, modulate always
  always_comb begin
    gain_d   = gain_q;
    gain_s_d = gain_s_q;
    hold_l_d = hold_l_q;
    hold_r_d = hold_r_q;
    muted_d  = muted_q;
    if (enable) begin
      hold_l_d = sound_in_l;
      hold_r_d = sound_in_r;
      gain_s_d = gain_q;
      if (mute && (gain_q != GAIN_ZERO)) begin
        gain_d = gain_q - GAIN_ONE;
      end else if (!mute && (gain_q < GAIN_FULL)) begin
        gain_d = gain_q + GAIN_ONE;
      end else begin
        gain_d = gain_q;
      end
      muted_d = (gain_d == GAIN_ZERO);
    end else begin
      gain_d  = gain_q;
      muted_d = muted_q;
    end
    cap_d = enable;

    // Full-scale gain is a power of two, so the product shifted down always fits DATA_W
    prod_l_s = PW'(hold_l_q) * PW'(gain_s_q);
    prod_r_s = PW'(hold_r_q) * PW'(gain_s_q);
    if (cap_q) begin
      scaled_l_d = DATA_W'(prod_l_s >> SH);
      scaled_r_d = DATA_W'(prod_r_s >> SH);
    end else begin
      scaled_l_d = scaled_l_q;
      scaled_r_d = scaled_r_q;
    end

    sum_l_s = {1'b0, acc_l_q} + {1'b0, scaled_l_q};
    sum_r_s = {1'b0, acc_r_q} + {1'b0, scaled_r_q};
    acc_l_d = sum_l_s[DATA_W-1:0];
    acc_r_d = sum_r_s[DATA_W-1:0];
    dac_l_d = sum_l_s[DATA_W];
    dac_r_d = sum_r_s[DATA_W];
  end

  // State registers with synchronous reset to the muted, silent state
  always_ff @(posedge clk) begin
    if (reset) begin
      gain_q     <= GAIN_ZERO;
      gain_s_q   <= GAIN_ZERO;
      hold_l_q   <= {DATA_W{1'b0}};
      hold_r_q   <= {DATA_W{1'b0}};
      cap_q      <= 1'b0;
      scaled_l_q <= {DATA_W{1'b0}};
      scaled_r_q <= {DATA_W{1'b0}};
      acc_l_q    <= {DATA_W{1'b0}};
      acc_r_q    <= {DATA_W{1'b0}};
      dac_l_q    <= 1'b0;
      dac_r_q    <= 1'b0;
      muted_q    <= 1'b1;
    end else begin
      gain_q     <= gain_d;
      gain_s_q   <= gain_s_d;
      hold_l_q   <= hold_l_d;
      hold_r_q   <= hold_r_d;
      cap_q      <= cap_d;
      scaled_l_q <= scaled_l_d;
      scaled_r_q <= scaled_r_d;
      acc_l_q    <= acc_l_d;
      acc_r_q    <= acc_r_d;
      dac_l_q    <= dac_l_d;
      dac_r_q    <= dac_r_d;
      muted_q    <= muted_d;
    end
  end

  assign dac_l = dac_l_q;
  assign dac_r = dac_r_q;
  assign muted = muted_q;

endmodule
